ddr3_cmd_arbiter: RTL
=====================

# ddr3_cmd_arbiter

Two-requester arbiter that shares a single DDR3 command/write/read channel set between two masters, e.g. the ORAM backend and the memory initializer. It sits directly in front of the DDR3 controller or model, upstream of the width shifters and read-data FIFO. Grants alternate round-robin on whole transactions: command plus its write-data beats. An in-order tag queue steers returning read data back to the requester that issued the read.

## Interface
- AWidth, 28: DDR3 address width (DDRAWidth)
- CWidth, 3: DDR3 command width (DDRCWidth)
- DWidth, 512: DDR3 data width (DDRDWidth)
- WBeats, 1: write-data beats per write command, ≥1
- TagDepth, 64: maximum outstanding reads, power of two
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Rn_Address / Rn_Command / Rn_CommandValid  in  AWidth/CWidth/1  requester n∈{0,1} command
- Rn_CommandReady  out  1  command accepted for requester n
- Rn_WriteData / Rn_WriteValid  in  DWidth/1  requester n write data
- Rn_WriteReady  out  1  write beat accepted from requester n
- Rn_ReadData / Rn_ReadValid  out  DWidth/1  read data to requester n
- Rn_ReadReady  in  1  requester n accepts read data
- DDR3SDRAM_Address / DDR3SDRAM_Command / DDR3SDRAM_CommandValid  out  AWidth/CWidth/1  to memory
- DDR3SDRAM_CommandReady  in  1  memory accepts command
- DDR3SDRAM_WriteData / DDR3SDRAM_WriteValid  out  DWidth/1  to memory
- DDR3SDRAM_WriteReady  in  1
- DDR3SDRAM_ReadData / DDR3SDRAM_ReadValid  in  DWidth/1  from memory
- DDR3SDRAM_ReadReady  out  1
- Error  out  1  sticky; set when read data arrives with no outstanding tag

## Operation
- FSM states: ST_Idle, ST_Cmd, ST_WData.
- ST_Idle:
  - Port n is eligible when Rn_CommandValid is high and it is not (Rn_Command==DDR3CMD_Read with TagCount==TagDepth).
  - If both ports are eligible, grant the port ≠ LastGrant. Otherwise grant the single eligible port.
  - Register Grant, update LastGrant, go to ST_Cmd.
  - If neither port is eligible, stay in ST_Idle.
- ST_Cmd:
  - Memory command outputs are a combinational mux of the granted port.
  - The granted port's CommandReady is DDR3SDRAM_CommandReady.
  - On acceptance of a read: push Grant into the tag queue, then go to ST_Idle.
  - On acceptance of a write: clear BeatCnt, then go to ST_WData.
- ST_WData:
  - The granted port's write channel is muxed to memory.
  - Each accepted beat increments BeatCnt.
  - When beat WBeats-1 is accepted, go to ST_Idle.
- Write data outside ST_WData is ignored: WriteReady is held 0 and memory WriteValid is held 0.
- Read return path operates independently of the FSM:
  - Head tag h selects the destination port: Rh_ReadValid = DDR3SDRAM_ReadValid && !empty.
  - DDR3SDRAM_ReadReady = Rh_ReadReady.
  - Pop the tag when DDR3SDRAM_ReadValid && DDR3SDRAM_ReadReady.
- Tag queue empty while DDR3SDRAM_ReadValid is high:
  - ReadReady = 1, so the data is drained and discarded.
  - Error is set.
- Requesters must hold Valid and payload stable until Ready.

## Timing
- Reset values:
  - State = ST_Idle, Grant = 0, LastGrant = 1, so port 0 wins the first tie.
  - TagCount = 0, Error = 0.
  - All Valid/Ready outputs = 0 except DDR3SDRAM_ReadReady, which follows the empty-queue rule.
- Arbitration latency: a request first seen in ST_Idle in cycle t is presented to memory in cycle t+1.
- A command transaction occupies at least 2 cycles; a write occupies at least 2+WBeats cycles.
- Read-data path has zero latency, purely combinational.
- Tag push and pop in the same cycle: TagCount is unchanged and both operations occur.
- The full check uses the registered TagCount, so a same-cycle pop does not enable a grant.
- Reset mid-transaction aborts the grant and empties the tag queue. In-flight reads are then lost and later reach the Error path.

## Configuration
- DDR3ARB_FIXED_PRIORITY_EN defined: port 0 always wins a tie and LastGrant is unused.
- DDR3ARB_FIXED_PRIORITY_EN undefined (default): round-robin as described in Operation.

## Structure
- Shared header DDR3ArbLocal.vh holds the ST_* state encodings and the state width.
- DDR3CMD_* constants come from the existing DDR3SDRAMLocal.vh.
- One sub-module, ddr3_arb_tag_fifo: 1-bit-wide, TagDepth-deep circular FIFO with count, full and empty flags.

## Test plan
- Only R0 issues a read at address 0x100; memory returns D: R0_ReadValid carries D, and R1_ReadValid stays 0 throughout.
- Both ports hold read requests continuously after reset: grant order is R0,R1,R0,R1…, and returned data alternates ports in the same order.
- R1 issues a write with WBeats=4 while R0 requests a read: R0 is not granted until the fourth R1 beat is accepted, and exactly 4 beats reach memory.
- TagDepth=4, reads issued with memory returning nothing: the 5th read is stalled in ST_Idle. After one data return, the 5th read is granted the cycle after the pop.
- R0_ReadReady=0 while data is destined to R0: DDR3SDRAM_ReadReady=0 and the data is held. Raising R0_ReadReady completes the transfer.
- DDR3SDRAM_ReadValid pulsed right after reset with an empty queue: Error=1 and remains set until Reset.

Source files
------------

// File: rtl/ddr3_cmd_arbiter_pkg.sv
// Shared definitions for the two-port DDR3 command arbiter: DDR3 command
// encodings and the arbiter FSM state type.
package ddr3_cmd_arbiter_pkg;

   localparam logic [2:0] DDR3CMD_WRITE = 3'd0;
   localparam logic [2:0] DDR3CMD_READ  = 3'd1;

   localparam int ARB_STATE_W = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WDATA = 2'd2
   } arb_state_e;

endpackage

// File: rtl/ddr3_cmd_arbiter_if.sv
// DDR3 command / write / read channel bundle. The master side issues
// commands and write data and consumes read data; the slave side is the
// memory (or the arbiter facing a requester).
interface ddr3_cmd_arbiter_if #(
   parameter int A_WIDTH = 28,
   parameter int C_WIDTH = 3,
   parameter int D_WIDTH = 512
);
   logic [A_WIDTH-1:0] address;
   logic [C_WIDTH-1:0] command;
   logic               command_valid;
   logic               command_ready;
   logic [D_WIDTH-1:0] write_data;
   logic               write_valid;
   logic               write_ready;
   logic [D_WIDTH-1:0] read_data;
   logic               read_valid;
   logic               read_ready;

   modport master (
      output address, command, command_valid,
      input  command_ready,
      output write_data, write_valid,
      input  write_ready,
      input  read_data, read_valid,
      output read_ready
   );

   modport slave (
      input  address, command, command_valid,
      output command_ready,
      input  write_data, write_valid,
      output write_ready,
      output read_data, read_valid,
      input  read_ready
   );
endinterface

// File: rtl/ddr3_arb_tag_fifo.sv
// In-order tag queue for outstanding reads: one bit per entry naming the
// requester that issued the read. Circular buffer with occupancy count.
// The arbiter never pushes when full nor pops when empty.
module ddr3_arb_tag_fifo #(
   parameter int DEPTH = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   // Next-state for storage, pointers and count; push+pop leaves count unchanged.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Queue state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Two-requester arbiter in front of a DDR3 controller. Whole transactions
// (command plus its write beats) are granted round-robin; returning read
// data is steered by an in-order tag queue.
// Optional build macro DDR3ARB_FIXED_PRIORITY_EN: port 0 always wins a tie.
//
// state    | meaning
// ST_IDLE  | choose an eligible requester, register the grant
// ST_CMD   | granted command muxed to memory, wait for acceptance
// ST_WDATA | granted write beats muxed to memory until the last is taken
module ddr3_cmd_arbiter
   import ddr3_cmd_arbiter_pkg::*;
#(
   parameter int A_WIDTH   = 28,
   parameter int C_WIDTH   = 3,
   parameter int D_WIDTH   = 512,
   parameter int W_BEATS   = 1,
   parameter int TAG_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst,
   ddr3_cmd_arbiter_if.slave  r0,
   ddr3_cmd_arbiter_if.slave  r1,
   ddr3_cmd_arbiter_if.master mem,
   output logic              error
);
   localparam int                BEAT_W    = (W_BEATS > 1) ? $clog2(W_BEATS) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(W_BEATS - 1);
   localparam logic [C_WIDTH-1:0] CMD_RD   = C_WIDTH'(DDR3CMD_READ);
   localparam logic [C_WIDTH-1:0] CMD_WR   = C_WIDTH'(DDR3CMD_WRITE);

   arb_state_e        state_q, state_d;
   logic              grant_q, grant_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              error_q, error_d;

   logic              tag_push, tag_pop, tag_head, tag_full, tag_empty;
   logic              elig0, elig1, tie_pick;
   logic              cmd_fire, beat_fire, rd_ready;

   logic [A_WIDTH-1:0] g_address;
   logic [C_WIDTH-1:0] g_command;
   logic               g_command_valid;
   logic [D_WIDTH-1:0] g_write_data;
   logic               g_write_valid;

   // A read is held off while the tag queue is full (registered occupancy).
   assign elig0 = r0.command_valid && !((r0.command == CMD_RD) && tag_full);
   assign elig1 = r1.command_valid && !((r1.command == CMD_RD) && tag_full);

`ifdef DDR3ARB_FIXED_PRIORITY_EN
   assign tie_pick = 1'b0;
`else
   logic last_grant_q, last_grant_d;

   assign tie_pick = ~last_grant_q;

   // Remember who won the last arbitration round.
   always_comb begin
      last_grant_d = last_grant_q;
      if ((state_q == ST_IDLE) && (elig0 || elig1)) begin
         last_grant_d = grant_d;
      end
   end

   // Round-robin history; reset to 1 so port 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   // Granted requester's command and write channel.
   always_comb begin
      g_address       = grant_q ? r1.address       : r0.address;
      g_command       = grant_q ? r1.command       : r0.command;
      g_command_valid = grant_q ? r1.command_valid : r0.command_valid;
      g_write_data    = grant_q ? r1.write_data    : r0.write_data;
      g_write_valid   = grant_q ? r1.write_valid   : r0.write_valid;
   end

   assign cmd_fire  = (state_q == ST_CMD)   && g_command_valid && mem.command_ready;
   assign beat_fire = (state_q == ST_WDATA) && g_write_valid   && mem.write_ready;

   // Arbitration FSM next state, grant, beat counter and tag push.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      tag_push   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (elig0 || elig1) begin
               grant_d = (elig0 && elig1) ? tie_pick : elig1;
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            if (cmd_fire) begin
               if (g_command == CMD_RD) begin
                  tag_push = 1'b1;
                  state_d  = ST_IDLE;
               end else if (g_command == CMD_WR) begin
                  beat_cnt_d = '0;
                  state_d    = ST_WDATA;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WDATA: begin
            if (beat_fire) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == BEAT_LAST) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= 1'b0;
         beat_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         error_q    <= error_d;
      end
   end

   // Command and write channels to memory; ready only reaches the granted port.
   always_comb begin
      mem.address       = g_address;
      mem.command       = g_command;
      mem.command_valid = 1'b0;
      mem.write_data    = g_write_data;
      mem.write_valid   = 1'b0;
      r0.command_ready  = 1'b0;
      r1.command_ready  = 1'b0;
      r0.write_ready    = 1'b0;
      r1.write_ready    = 1'b0;
      if (state_q == ST_CMD) begin
         mem.command_valid = g_command_valid;
         r0.command_ready  = !grant_q && mem.command_ready;
         r1.command_ready  =  grant_q && mem.command_ready;
      end
      if (state_q == ST_WDATA) begin
         mem.write_valid = g_write_valid;
         r0.write_ready  = !grant_q && mem.write_ready;
         r1.write_ready  =  grant_q && mem.write_ready;
      end
   end

   // Read return: head tag picks the destination; untagged data is drained.
   always_comb begin
      r0.read_data  = mem.read_data;
      r1.read_data  = mem.read_data;
      r0.read_valid = mem.read_valid && !tag_empty && !tag_head;
      r1.read_valid = mem.read_valid && !tag_empty &&  tag_head;
      rd_ready      = tag_empty ? 1'b1 : (tag_head ? r1.read_ready : r0.read_ready);
      mem.read_ready = rd_ready;
      tag_pop       = mem.read_valid && rd_ready && !tag_empty;
      error_d       = error_q || (mem.read_valid && tag_empty);
   end

   assign error = error_q;

   ddr3_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_push),
      .din   (grant_q),
      .pop   (tag_pop),
      .dout  (tag_head),
      .full  (tag_full),
      .empty (tag_empty)
   );

endmodule
